// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram -- CPU data memory with a small memory-mapped timer/GPIO block.
//
// Address map (addr[31:28]):
//   0x0  word RAM, 2**DEPTH_LOG2 words, indexed by addr[DEPTH_LOG2+1:2]
//        (higher RAM-region bits ignored, so the RAM aliases/wraps)
//   0x1  MMIO, register picked by addr[3:2]:
//          0 COUNT   free-running 32-bit counter, writable per byte lane
//          1 COMPARE 32-bit compare value
//          2 STATUS  bit0 MATCH (sticky, write 1 to clear), bit1 IE
//          3 GPIO    8-bit output register (lane 0 only)
//   else unmapped: reads 0, writes ignored
//
// Ports:
//   clk     single clock, all state changes on the rising edge
//   rst     synchronous active-high reset (RAM contents are not reset)
//   ce      access enable from the CPU memory stage
//   we      1 = write, 0 = read (only meaningful when ce = 1)
//   addr    byte address, bits [1:0] ignored
//   sel     byte-lane enables, sel[i] covers bits [8i+7:8i]
//   data_i  write data
//   data_o  combinational read data (0 when not reading)
//   irq     MATCH AND IE, registered
//   gpio_o  GPIO register contents
// ---------------------------------------------------------------------------
module data_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq,
  output logic [7:0]  gpio_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] OFS_COUNT   = 2'd0;
  localparam logic [1:0] OFS_COMPARE = 2'd1;
  localparam logic [1:0] OFS_STATUS  = 2'd2;
  localparam logic [1:0] OFS_GPIO    = 2'd3;

  // Replace the lanes enabled in laneSel with the matching lanes of newWord.
  function automatic logic [31:0] laneMerge(
    input logic [31:0] oldWord,
    input logic [31:0] newWord,
    input logic [3:0]  laneSel
  );
    logic [31:0] merged;
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (laneSel[i]) begin
        merged[8*i +: 8] = newWord[8*i +: 8];
      end else begin
        merged[8*i +: 8] = oldWord[8*i +: 8];
      end
    end
    return merged;
  endfunction

  logic [31:0] memR [DEPTH];

  logic [31:0] countR;
  logic [31:0] compareR;
  logic        matchR;
  logic        ieR;
  logic [7:0]  gpioR;
  logic        irqR;

  logic [DEPTH_LOG2-1:0] wordIdxS;
  logic        ramHitS;
  logic        mmioHitS;
  logic        rdEnS;
  logic        wrEnS;
  logic        ramWrS;
  logic        countWrS;
  logic        compareWrS;
  logic        statusWrS;
  logic        gpioWrS;
  logic [31:0] countNextS;
  logic [31:0] compareNextS;
  logic        matchNextS;
  logic        ieNextS;
  logic [7:0]  gpioNextS;
  logic        unusedAddrS;

  assign wordIdxS = addr[DEPTH_LOG2+1:2];
  assign ramHitS  = (addr[31:28] == 4'h0);
  assign mmioHitS = (addr[31:28] == 4'h1);
  assign rdEnS    = ce & ~we;
  assign wrEnS    = ce & we;

  assign ramWrS     = wrEnS & ramHitS;
  assign countWrS   = wrEnS & mmioHitS & (addr[3:2] == OFS_COUNT);
  assign compareWrS = wrEnS & mmioHitS & (addr[3:2] == OFS_COMPARE);
  assign statusWrS  = wrEnS & mmioHitS & (addr[3:2] == OFS_STATUS);
  assign gpioWrS    = wrEnS & mmioHitS & (addr[3:2] == OFS_GPIO);

  // Byte-offset bits and region-internal bits that no decoder looks at.
  assign unusedAddrS = ^addr;

  // Next-state values for the MMIO registers.
  always_comb begin
    countNextS   = countR + 32'd1;
    compareNextS = compareR;
    matchNextS   = matchR;
    ieNextS      = ieR;
    gpioNextS    = gpioR;

    // A COUNT write replaces the increment; untouched lanes hold their value.
    if (countWrS) begin
      countNextS = laneMerge(countR, data_i, sel);
    end else begin
      countNextS = countR + 32'd1;
    end

    if (compareWrS) begin
      compareNextS = laneMerge(compareR, data_i, sel);
    end else begin
      compareNextS = compareR;
    end

    // Clear first, then a same-cycle match sets it again (set wins).
    if (statusWrS && sel[0]) begin
      ieNextS    = data_i[1];
      matchNextS = matchR & ~data_i[0];
    end else begin
      ieNextS    = ieR;
      matchNextS = matchR;
    end
    if (countR == compareR) begin
      matchNextS = 1'b1;
    end else begin
      matchNextS = matchNextS;
    end

    if (gpioWrS && sel[0]) begin
      gpioNextS = data_i[7:0];
    end else begin
      gpioNextS = gpioR;
    end
  end

  // MMIO register bank; reset overrides any write or increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      countR   <= 32'h0000_0000;
      compareR <= 32'hFFFF_FFFF;
      matchR   <= 1'b0;
      ieR      <= 1'b0;
      gpioR    <= 8'h00;
      irqR     <= 1'b0;
    end else begin
      countR   <= countNextS;
      compareR <= compareNextS;
      matchR   <= matchNextS;
      ieR      <= ieNextS;
      gpioR    <= gpioNextS;
      // irq tracks the registered MATCH/IE pair exactly, one flop deep.
      irqR     <= matchNextS & ieNextS;
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ramWrS) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          memR[wordIdxS][8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
  end

  // Combinational read mux; anything other than a mapped read returns zero.
  always_comb begin
    data_o = 32'h0000_0000;
    if (rdEnS && ramHitS) begin
      data_o = memR[wordIdxS];
    end else if (rdEnS && mmioHitS) begin
      case (addr[3:2])
        OFS_COUNT:   data_o = countR;
        OFS_COMPARE: data_o = compareR;
        OFS_STATUS:  data_o = {30'd0, ieR, matchR};
        OFS_GPIO:    data_o = {24'd0, gpioR};
        default:     data_o = 32'h0000_0000;
      endcase
    end else begin
      data_o = 32'h0000_0000;
    end
  end

  assign irq    = irqR;
  assign gpio_o = gpioR;

endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;

  localparam logic [31:0] A_COUNT   = 32'h1000_0000;
  localparam logic [31:0] A_COMPARE = 32'h1000_0004;
  localparam logic [31:0] A_STATUS  = 32'h1000_0008;
  localparam logic [31:0] A_GPIO    = 32'h1000_000C;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        irq;
  logic [7:0]  gpioOut;

  int nCompared   = 0;
  int nMismatched = 0;

  data_ram #(.DEPTH_LOG2(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .sel    (sel),
    .data_i (dataIn),
    .data_o (dataOut),
    .irq    (irq),
    .gpio_o (gpioOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus: one write cycle, returns 1 time unit after the write edge.
  task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; dataIn = d; sel = s;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
  endtask

  // Stimulus: combinational read in the low phase of the clock.
  task automatic doRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'b1111;
    #1;
    d = dataOut;
    ce = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nCompared++;
    if (irq !== 1'b0) begin nMismatched++; $display("FAIL reset_irq: got %b expected 0", irq); end
    nCompared++;
    if (gpioOut !== 8'h00) begin nMismatched++; $display("FAIL reset_gpio: got %h expected 00", gpioOut); end
    doRead(A_COUNT, r);
    nCompared++;
    if (r !== 32'h0000_0000) begin nMismatched++; $display("FAIL reset_count: got %h expected 00000000", r); end
    doRead(A_COMPARE, r);
    nCompared++;
    if (r !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL reset_compare: got %h expected ffffffff", r); end
    doRead(A_STATUS, r);
    nCompared++;
    if (r !== 32'h0000_0000) begin nMismatched++; $display("FAIL reset_status: got %h expected 00000000", r); end
  endtask

  task automatic test_count();
    logic [31:0] r;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    doRead(A_COUNT, r);
    nCompared++;
    if (r !== 32'd5) begin nMismatched++; $display("FAIL count_after5: got %h expected 00000005", r); end
    doWrite(A_COUNT, 32'hFFFF_FFFE, 4'b1111);
    doRead(A_COUNT, r);
    nCompared++;
    if (r !== 32'hFFFF_FFFE) begin nMismatched++; $display("FAIL count_load: got %h expected fffffffe", r); end
    doRead(A_COUNT, r);
    nCompared++;
    if (r !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL count_max: got %h expected ffffffff", r); end
    doRead(A_COUNT, r);
    nCompared++;
    if (r !== 32'h0000_0000) begin nMismatched++; $display("FAIL count_wrap: got %h expected 00000000", r); end
    // COUNT is 1 when this write is driven; lanes 2..0 must hold 000001.
    doWrite(A_COUNT, 32'hAA00_0000, 4'b1000);
    doRead(A_COUNT, r);
    nCompared++;
    if (r !== 32'hAA00_0001) begin nMismatched++; $display("FAIL count_lane: got %h expected aa000001", r); end
  endtask

  task automatic test_ram();
    logic [31:0] r;
    doWrite(32'h0000_0010, 32'h1234_5678, 4'b1111);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h0000_0010; dataIn = 32'h00AB_0000; sel = 4'b0100;
    #1;
    nCompared++;
    if (dataOut !== 32'h0000_0000) begin nMismatched++; $display("FAIL ram_write_cycle_dout: got %h expected 00000000", dataOut); end
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
    doRead(32'h0000_0010, r);
    nCompared++;
    if (r !== 32'h12AB_5678) begin nMismatched++; $display("FAIL ram_lane_merge: got %h expected 12ab5678", r); end
    doRead(32'h0000_1010, r);
    nCompared++;
    if (r !== 32'h12AB_5678) begin nMismatched++; $display("FAIL ram_alias: got %h expected 12ab5678", r); end
    doWrite(32'h0000_0010, 32'hDEAD_BEEF, 4'b0000);
    doRead(32'h0000_0010, r);
    nCompared++;
    if (r !== 32'h12AB_5678) begin nMismatched++; $display("FAIL ram_sel_none: got %h expected 12ab5678", r); end
    doWrite(32'h0000_1014, 32'hCAFE_F00D, 4'b1111);
    doRead(32'h0000_0014, r);
    nCompared++;
    if (r !== 32'hCAFE_F00D) begin nMismatched++; $display("FAIL ram_wrap_write: got %h expected cafef00d", r); end
    @(negedge clk);
    ce = 1'b0; we = 1'b0; addr = 32'h0000_0010;
    #1;
    nCompared++;
    if (dataOut !== 32'h0000_0000) begin nMismatched++; $display("FAIL ram_ce_low: got %h expected 00000000", dataOut); end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    doWrite(32'h0000_0000, 32'h0000_0000, 4'b1111);
    doRead(32'h2000_0000, r);
    nCompared++;
    if (r !== 32'h0000_0000) begin nMismatched++; $display("FAIL unmapped_read: got %h expected 00000000", r); end
    doWrite(32'h2000_0000, 32'hFFFF_FFFF, 4'b1111);
    doRead(32'h0000_0000, r);
    nCompared++;
    if (r !== 32'h0000_0000) begin nMismatched++; $display("FAIL unmapped_write: got %h expected 00000000", r); end
  endtask

  task automatic test_match();
    logic [31:0] r;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    doWrite(A_COMPARE, 32'd20, 4'b1111);
    doWrite(A_STATUS, 32'h0000_0002, 4'b1111);
    doWrite(A_COUNT, 32'd0, 4'b1111);
    repeat (20) @(posedge clk);
    #1;
    nCompared++;
    if (irq !== 1'b0) begin nMismatched++; $display("FAIL match_early_irq: got %b expected 0", irq); end
    doRead(A_STATUS, r);
    nCompared++;
    if (r !== 32'h0000_0002) begin nMismatched++; $display("FAIL match_early_status: got %h expected 00000002", r); end
    @(posedge clk);
    #1;
    nCompared++;
    if (irq !== 1'b1) begin nMismatched++; $display("FAIL match_irq: got %b expected 1", irq); end
    doRead(A_STATUS, r);
    nCompared++;
    if (r !== 32'h0000_0003) begin nMismatched++; $display("FAIL match_status: got %h expected 00000003", r); end
    doWrite(A_STATUS, 32'h0000_0003, 4'b1111);
    doRead(A_STATUS, r);
    nCompared++;
    if (r !== 32'h0000_0002) begin nMismatched++; $display("FAIL match_clear: got %h expected 00000002", r); end
    nCompared++;
    if (irq !== 1'b0) begin nMismatched++; $display("FAIL match_clear_irq: got %b expected 0", irq); end
    // COUNT is 19 after this edge and 20 during the STATUS write: set wins.
    doWrite(A_COUNT, 32'd19, 4'b1111);
    @(posedge clk);
    doWrite(A_STATUS, 32'h0000_0003, 4'b1111);
    doRead(A_STATUS, r);
    nCompared++;
    if (r !== 32'h0000_0003) begin nMismatched++; $display("FAIL match_collision: got %h expected 00000003", r); end
    nCompared++;
    if (irq !== 1'b1) begin nMismatched++; $display("FAIL match_collision_irq: got %b expected 1", irq); end
  endtask

  task automatic test_gpio();
    logic [31:0] r;
    doWrite(A_GPIO, 32'h0000_01A5, 4'b0001);
    nCompared++;
    if (gpioOut !== 8'hA5) begin nMismatched++; $display("FAIL gpio_out: got %h expected a5", gpioOut); end
    doRead(A_GPIO, r);
    nCompared++;
    if (r !== 32'h0000_00A5) begin nMismatched++; $display("FAIL gpio_read: got %h expected 000000a5", r); end
    doWrite(A_GPIO, 32'hFFFF_FF5A, 4'b1110);
    nCompared++;
    if (gpioOut !== 8'hA5) begin nMismatched++; $display("FAIL gpio_nolane0: got %h expected a5", gpioOut); end
    doRead(A_GPIO, r);
    nCompared++;
    if (r !== 32'h0000_00A5) begin nMismatched++; $display("FAIL gpio_nolane0_read: got %h expected 000000a5", r); end
  endtask

  task automatic test_reset_priority();
    logic [31:0] r;
    nCompared++;
    if (irq !== 1'b1 || gpioOut !== 8'hA5) begin
      nMismatched++; $display("FAIL rstpri_pre: got irq=%b gpio=%h expected irq=1 gpio=a5", irq, gpioOut);
    end
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; we = 1'b1; addr = A_COUNT; dataIn = 32'h0000_0055; sel = 4'b1111;
    @(posedge clk);
    #1;
    nCompared++;
    if (irq !== 1'b0) begin nMismatched++; $display("FAIL rstpri_irq: got %b expected 0", irq); end
    nCompared++;
    if (gpioOut !== 8'h00) begin nMismatched++; $display("FAIL rstpri_gpio: got %h expected 00", gpioOut); end
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; we = 1'b0; addr = A_COUNT;
    #1;
    nCompared++;
    if (dataOut !== 32'h0000_0000) begin nMismatched++; $display("FAIL rstpri_count: got %h expected 00000000", dataOut); end
    ce = 1'b0;
    doRead(A_COMPARE, r);
    nCompared++;
    if (r !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL rstpri_compare: got %h expected ffffffff", r); end
    doRead(32'h0000_0010, r);
    nCompared++;
    if (r !== 32'h12AB_5678) begin nMismatched++; $display("FAIL rstpri_ram: got %h expected 12ab5678", r); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'b0000; dataIn = 32'h0;
    test_reset();
    test_count();
    test_ram();
    test_unmapped();
    test_match();
    test_gpio();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
